// File: rtl/ex_pkg.sv
// Shared types and constants for the execute-stage back end.
// Latency: none (declarations only).
// Backpressure: n/a.
package ex_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  // ALU function class, taken from alu_fun[4:3]
  localparam logic [1:0] CLS_ARITH   = 2'b00;
  localparam logic [1:0] CLS_ARITH_I = 2'b01;
  localparam logic [1:0] CLS_ADDR    = 2'b10;
  localparam logic [1:0] CLS_SHIFT   = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
  } ex_entry_t;

  // Address calculations leave the architectural flags alone
  function automatic logic cls_writes_flags(input logic [1:0] cls);
    return cls != CLS_ADDR;
  endfunction

endpackage

// File: rtl/ex_result_stage_if.sv
// ALU-side input bundle and memory/writeback-side output bundle of the stage.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready handshakes carried as plain signals.
interface ex_result_stage_if;
  import ex_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_cout;
  logic [4:0]        alu_fun;
  logic [REG_AW-1:0] in_dest;
  logic              in_wb_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_AW-1:0] out_dest;
  logic              out_wb_en;

  // The result stage itself
  modport slave (
    input  in_valid, alu_result, alu_zero, alu_cout, alu_fun, in_dest, in_wb_en,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_dest, out_wb_en
  );

  // The ALU plus the downstream consumer
  modport master (
    output in_valid, alu_result, alu_zero, alu_cout, alu_fun, in_dest, in_wb_en,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_dest, out_wb_en
  );

endinterface

// File: rtl/ex_skid_buf.sv
// Two-entry elastic buffer (output register + skid register) of ex_entry_t.
// Latency: 1 cycle from push to pop_vld when the output register is free.
// Backpressure: push_rdy is registered (skid empty); a stall parks one entry in skid.
module ex_skid_buf
  import ex_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push_vld,
  output logic      push_rdy,
  input  ex_entry_t push_dat,
  output logic      pop_vld,
  input  logic      pop_rdy,
  output ex_entry_t pop_dat
);

  logic      out_vld_q, out_vld_d;
  ex_entry_t out_dat_q, out_dat_d;
  logic      skid_vld_q, skid_vld_d;
  ex_entry_t skid_dat_q, skid_dat_d;
  logic      xfer;

  // Next-state: refill output from skid first, then from the new push; park in skid when stalled
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    xfer       = out_vld_q && pop_rdy;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || xfer) begin
      if (skid_vld_q) begin
        // push_vld cannot be set here: push_rdy is low while skid holds data
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (push_vld) begin
        out_vld_d = 1'b1;
        out_dat_d = push_dat;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push_vld) begin
      skid_vld_d = 1'b1;
      skid_dat_d = push_dat;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign push_rdy = !skid_vld_q;
  assign pop_vld  = out_vld_q;
  assign pop_dat  = out_dat_q;

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage back end: buffers ALU results for writeback and owns the C/Z flags (FLAG_SAVE_EN adds a shadow).
// Latency: 1 cycle accept-to-output; flags visible on cin the cycle after accept.
// Backpressure: out_ready stall fills the skid entry, then in_ready drops until it drains.
module ex_result_stage
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ex_result_stage_if.slave    io,
  input  logic                flush,
`ifdef FLAG_SAVE_EN
  input  logic                flag_save,
  input  logic                flag_restore,
`endif
  output logic                flag_c,
  output logic                flag_z,
  output logic                cin
);

  logic      accept;
  logic      push_rdy;
  ex_entry_t push_dat;
  ex_entry_t pop_dat;
  logic      flag_c_q, flag_c_d;
  logic      flag_z_q, flag_z_d;
  logic      unused_fun_lo;

  assign accept            = io.in_valid && push_rdy && !flush;
  assign push_dat.result   = io.alu_result;
  assign push_dat.dest     = io.in_dest;
  assign push_dat.wb_en    = io.in_wb_en;
  assign unused_fun_lo     = ^io.alu_fun[2:0];

  ex_skid_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (accept),
    .push_rdy (push_rdy),
    .push_dat (push_dat),
    .pop_vld  (io.out_valid),
    .pop_rdy  (io.out_ready),
    .pop_dat  (pop_dat)
  );

  assign io.in_ready   = push_rdy;
  assign io.out_result = pop_dat.result;
  assign io.out_dest   = pop_dat.dest;
  assign io.out_wb_en  = pop_dat.wb_en;

`ifdef FLAG_SAVE_EN
  logic shadow_c_q, shadow_c_d;
  logic shadow_z_q, shadow_z_d;
`endif

  // Flag next-state: accepted non-address ops load C/Z; a restore overrides that update
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (accept && cls_writes_flags(io.alu_fun[4:3])) begin
      flag_c_d = io.alu_cout;
      flag_z_d = io.alu_zero;
    end
`ifdef FLAG_SAVE_EN
    shadow_c_d = shadow_c_q;
    shadow_z_d = shadow_z_q;
    if (flag_restore) begin
      flag_c_d = shadow_c_q;
      flag_z_d = shadow_z_q;
    end
    // Saving captures the flags as they stand before this cycle's update
    if (flag_save) begin
      shadow_c_d = flag_c_q;
      shadow_z_d = flag_z_q;
    end
`endif
  end

  // Architectural flag registers (and shadow when present)
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
`ifdef FLAG_SAVE_EN
      shadow_c_q <= 1'b0;
      shadow_z_q <= 1'b0;
`endif
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
`ifdef FLAG_SAVE_EN
      shadow_c_q <= shadow_c_d;
      shadow_z_q <= shadow_z_d;
`endif
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign cin    = flag_c_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized scoreboard bench for ex_result_stage: expected entries queued at accept, popped on transfer.
module tb_ex_result_stage;
  import ex_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  logic flag_save;
  logic flag_restore;
  logic flag_c;
  logic flag_z;
  logic cin;

  ex_result_stage_if ifc ();

  ex_result_stage dut (
    .clk          (clk),
    .rst          (rst),
    .io           (ifc),
    .flush        (flush),
`ifdef FLAG_SAVE_EN
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
`endif
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .cin          (cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        vectors = 0;
  int        miscompares = 0;
  ex_entry_t q[$];
  bit        mc = 0, mz = 0, sc = 0, sz = 0;
  bit        mdl_rdy = 1;
  bit        mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: occupancy-derived handshake checks, then pop and compare on each transfer
  always @(negedge clk) begin
    if (mon_en) begin
      ex_entry_t e;
      chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, q.size() < 2});
      mdl_rdy = (q.size() < 2);
      if (!rst && !flush && ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_result", {24'd0, ifc.out_result}, {24'd0, e.result});
          chk("out_dest", {29'd0, ifc.out_dest}, {29'd0, e.dest});
          chk("out_wb_en", {31'd0, ifc.out_wb_en}, {31'd0, e.wb_en});
        end
      end
    end
  end

  // Reference model of the flag register and of what the buffer must hold
  task automatic model_update();
    bit        acc;
    bit        oc, oz;
    ex_entry_t e;
    if (mon_en) begin
      chk("flag_c", {31'd0, flag_c}, {31'd0, mc});
      chk("flag_z", {31'd0, flag_z}, {31'd0, mz});
      chk("cin", {31'd0, cin}, {31'd0, mc});
    end
    if (rst) begin
      q.delete();
      mc = 0; mz = 0; sc = 0; sz = 0;
    end else begin
      acc = ifc.in_valid && mdl_rdy && !flush;
      if (flush) q.delete();
      if (acc) begin
        e.result = ifc.alu_result;
        e.dest   = ifc.in_dest;
        e.wb_en  = ifc.in_wb_en;
        q.push_back(e);
      end
      oc = mc; oz = mz;
      if (acc && ifc.alu_fun[4:3] != 2'b10) begin
        mc = ifc.alu_cout;
        mz = ifc.alu_zero;
      end
`ifdef FLAG_SAVE_EN
      if (flag_restore) begin
        mc = sc; mz = sz;
      end
      if (flag_save) begin
        sc = oc; sz = oz;
      end
`endif
    end
  endtask

  task automatic step(input bit v, input logic [7:0] res, input bit z, input bit c,
                      input logic [4:0] fun, input logic [2:0] dst, input bit wb,
                      input bit fl, input bit ordy,
                      input bit sv = 1'b0, input bit rs = 1'b0, input bit r = 1'b0);
    @(posedge clk);
    #1;
    rst            = r;
    flush          = fl;
    ifc.in_valid   = v;
    ifc.alu_result = res;
    ifc.alu_zero   = z;
    ifc.alu_cout   = c;
    ifc.alu_fun    = fun;
    ifc.in_dest    = dst;
    ifc.in_wb_en   = wb;
    ifc.out_ready  = ordy;
    flag_save      = sv;
    flag_restore   = rs;
    @(negedge clk);
    #1;
    model_update();
  endtask

  task automatic idle(input bit ordy);
    step(0, 8'h00, 0, 0, 5'd0, 3'd0, 0, 0, ordy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flag_save = 1'b0; flag_restore = 1'b0;
    ifc.in_valid = 1'b0; ifc.alu_result = '0; ifc.alu_zero = 1'b0; ifc.alu_cout = 1'b0;
    ifc.alu_fun = '0; ifc.in_dest = '0; ifc.in_wb_en = 1'b0; ifc.out_ready = 1'b0;

    step(0, 8'h00, 0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 1);
    mon_en = 1;
    step(0, 8'h00, 0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 1);
    chk("rst_out_result", {24'd0, ifc.out_result}, 32'd0);
    chk("rst_out_dest", {29'd0, ifc.out_dest}, 32'd0);
    chk("rst_out_wb_en", {31'd0, ifc.out_wb_en}, 32'd0);
    idle(1);

    // zero result with carry sets both flags, result arrives next cycle
    step(1, 8'h00, 1, 1, 5'b00000, 3'd3, 1, 0, 1);
    idle(1);
    chk("dir_cin_set", {31'd0, cin}, 32'd1);

    // stall: A lands in output, B in skid, then drain in order
    step(1, 8'h11, 0, 0, 5'b00001, 3'd1, 1, 0, 0);
    step(1, 8'h22, 0, 0, 5'b01000, 3'd2, 1, 0, 0);
    idle(0);
    chk("dir_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    idle(1);
    idle(1);
    idle(1);
    chk("dir_in_ready_back", {31'd0, ifc.in_ready}, 32'd1);

    // address-class op must not touch flags
    step(1, 8'h5a, 1, 1, 5'b10000, 3'd4, 1, 0, 1);
    idle(1);
    chk("dir_addr_flag_c", {31'd0, flag_c}, 32'd0);

    // fill skid then flush with a carry-producing op present
    step(1, 8'h33, 0, 0, 5'b00000, 3'd5, 1, 0, 0);
    step(1, 8'h44, 0, 0, 5'b00000, 3'd6, 0, 0, 0);
    idle(0);
    step(1, 8'h99, 0, 1, 5'b00000, 3'd7, 1, 1, 1);
    idle(1);
    chk("dir_flush_flag_c", {31'd0, flag_c}, 32'd0);
    idle(1);

`ifdef FLAG_SAVE_EN
    step(1, 8'h01, 0, 1, 5'b00000, 3'd1, 1, 0, 1);
    step(0, 8'h00, 0, 0, 5'd0, 3'd0, 0, 0, 1, 1, 0);
    step(1, 8'h02, 1, 0, 5'b00000, 3'd2, 1, 0, 1);
    step(0, 8'h00, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0, 1);
    step(1, 8'h03, 1, 0, 5'b11000, 3'd3, 1, 0, 1, 0, 1);
    idle(1);
    chk("dir_restore_wins_c", {31'd0, flag_c}, 32'd1);
    chk("dir_restore_wins_z", {31'd0, flag_z}, 32'd0);
`endif

    // randomized traffic with occasional flush, save/restore and one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1), 8'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), 3'($urandom), 1'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           (i == 750));
    end

    for (int i = 0; i < 4; i++) idle(1);
    chk("drain_queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
